req_capture: RTL
================

REQ_CAPTURE -- requirements
Module: req_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive cycles a synchronized button level must be stable to be accepted; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 12: cycles data is frozen after the request pulse, so the LRU stage can finish its multi-cycle search; legal range 10..65535.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 btn  input  1  raw, asynchronous, bouncing request push button; active-high.
REQ-006 sw_in  input  12  raw, asynchronous request value from the switches.
REQ-007 valid_data  output  1  one-cycle request strobe to the downstream LRU buffer.
REQ-008 data  output  12  captured request value; registered.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 btn and each sw_in bit SHALL pass through a two-flop synchronizer (btn_s, sw_s) before any use.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, FIRE, HOLD, WAIT_RELEASE, with one shared 16-bit counter cnt.
REQ-012 IDLE: if btn_s=1 -> DEBOUNCE, cnt<=0; otherwise stay in IDLE.
REQ-013 DEBOUNCE: if btn_s=0 -> IDLE (bounce rejected, no strobe); else if cnt=DEBOUNCE_CYCLES-1 -> FIRE and data<=sw_s; else cnt<=cnt+1.
REQ-014 FIRE: lasts exactly one cycle; valid_data=1 only in this state; -> HOLD, cnt<=0.
REQ-015 HOLD: if cnt=HOLD_CYCLES-1 -> WAIT_RELEASE, cnt<=0; else cnt<=cnt+1; btn_s is ignored.
REQ-016 WAIT_RELEASE: if btn_s=1, cnt<=0; else if cnt=DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-017 data SHALL change only on the DEBOUNCE->FIRE transition; it is stable in all other states, including through and after HOLD.
REQ-018 valid_data and busy SHALL be decoded from registered state, with no combinational path from btn or sw_in.
REQ-019 Latency: with btn held high, valid_data is high in the cycle after rising edge DEBOUNCE_CYCLES+3, where edge 1 is the first edge that samples btn=1.
REQ-020 A held button SHALL produce exactly one strobe; a new strobe requires release stable for DEBOUNCE_CYCLES cycles followed by a fresh debounced press.
REQ-021 sw_in changes during DEBOUNCE, FIRE, HOLD or WAIT_RELEASE SHALL NOT affect data; only the value in sw_s at the capturing edge is used.
REQ-022 The minimum spacing between two valid_data strobes SHALL be 1+HOLD_CYCLES+DEBOUNCE_CYCLES+1+DEBOUNCE_CYCLES+... cycles, i.e. never below HOLD_CYCLES+1.
REQ-023 Counter compares SHALL use equality against the parameter minus 1, with no wrap; DEBOUNCE_CYCLES=1 gives acceptance after a single stable cycle.

Reset
REQ-024 While rst=0, regardless of state: state=IDLE, cnt=0, synchronizer flops=0, data=12'd0, valid_data=0, busy=0, all taking effect immediately without waiting for a clock edge.
REQ-025 A reset asserted in any state, including FIRE, SHALL truncate the strobe at once; after release the FSM restarts from IDLE and a still-held button is treated as a new press.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=12)
REQ-026 Clean press: sw_in=12'hABC, btn high from edge 1 and held -> single valid_data pulse after edge 7, data=12'hABC, busy=1 from after edge 3.
REQ-027 Bounce: btn high for edges 1-3, low at edge 4, then stable high -> no strobe from the first burst; exactly one strobe after the stable period completes.
REQ-028 Value change during hold: sw_in switches to 12'h123 one cycle after the strobe -> data stays 12'hABC until the next accepted press.
REQ-029 Held button: btn held high for 100 cycles -> exactly one strobe; a release of 4+ cycles followed by a press -> a second strobe.
REQ-030 Reset mid-FIRE: rst=0 asserted during the valid_data cycle -> valid_data, busy and data go to 0 immediately; btn still high after release -> a new strobe after edge 7 counted from release.
REQ-031 Back-to-back with LRU: connect to lru_buffer and press 12'h001, 12'h002, then 12'h001 -> every strobe is separated by at least 13 cycles, and data is stable across each complete search.

Source files
------------

// File: rtl/req_capture.sv
// Push-button request capture: synchronizes a bouncing button and switch bank,
// debounces the press, emits one strobe with the captured value, then holds it.
module req_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [11:0] sw_in,
    output logic        valid_data,
    output logic [11:0] data,
    output logic        busy
);

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_FIRE,
        S_HOLD,
        S_WAIT_RELEASE
    } state_t;

    logic        r_btn_meta;
    logic        r_btn_sync;
    logic [11:0] r_sw_meta;
    logic [11:0] r_sw_sync;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [11:0] r_data;
    logic        r_valid;
    logic        r_busy;

    logic        w_btn_s;
    logic [11:0] w_sw_s;

    // Two-flop synchronizers; every later use sees only the second stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_sw_meta  <= 12'd0;
            r_sw_sync  <= 12'd0;
        end else begin
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= sw_in;
            r_sw_sync  <= r_sw_meta;
        end
    end

    assign w_btn_s = r_btn_sync;
    assign w_sw_s  = r_sw_sync;

    // Strobe and busy are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_data  <= 12'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= S_DEBOUNCE;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_btn_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= S_FIRE;
                        r_data  <= w_sw_s;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_FIRE: begin
                    r_state <= S_HOLD;
                    r_cnt   <= 16'd0;
                end
                S_HOLD: begin
                    // The button is deliberately ignored while the downstream search runs.
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_WAIT_RELEASE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (w_btn_s) begin
                        r_cnt <= 16'd0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_data = r_valid;
    assign data       = r_data;
    assign busy       = r_busy;

endmodule
